// File: rtl/timer_pkg.sv
// Shared definitions for the AXI4-Lite timer peripheral: register offsets,
// CTRL bit positions, AXI response codes, bus FSM states and a byte-lane merge helper.
package timer_pkg;

    // Register offsets within the decoded window (bits [1:0] are ignored)
    localparam logic [31:0] OFF_CTRL     = 32'h00;
    localparam logic [31:0] OFF_PRESCALE = 32'h04;
    localparam logic [31:0] OFF_COUNT    = 32'h08;
    localparam logic [31:0] OFF_COMPARE  = 32'h0C;
    localparam logic [31:0] OFF_STATUS   = 32'h10;

    // CTRL bit indices
    localparam int CTRL_EN          = 0;
    localparam int CTRL_IRQ_EN      = 1;
    localparam int CTRL_AUTO_RELOAD = 2;
    localparam int CTRL_W           = 3;

    // AXI response codes
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Write channel FSM: collecting AW/W, then holding the B response
    typedef enum logic {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } wr_state_t;

    // Read channel FSM: accepting AR, then holding the R response
    typedef enum logic {
        R_IDLE = 1'b0,
        R_RESP = 1'b1
    } rd_state_t;

    // Replace only the byte lanes whose strobe bit is set
    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[i*8 +: 8] = strb[i] ? new_val[i*8 +: 8] : old_val[i*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/axil_timer_core.sv
// Timer datapath: prescaler, 32-bit COUNT, sticky MATCH flag and interrupt level.
// Software-side effects arrive as single-cycle strobes from the bus logic.
module axil_timer_core
    import timer_pkg::*;
#(
    parameter int PRESC_W = 16
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               i_en,
    input  logic               i_irq_en,
    input  logic               i_auto_reload,
    input  logic [PRESC_W-1:0] i_prescale,
    input  logic [31:0]        i_compare,
    input  logic               i_count_load,
    input  logic [31:0]        i_count_wdata,
    input  logic               i_presc_clear,
    input  logic               i_match_clear,
    output logic [31:0]        o_count,
    output logic               o_match,
    output logic               o_irq
);

    logic [PRESC_W-1:0] r_presc;
    logic [31:0]        r_count;
    logic               r_match;
    logic               w_tick;
    logic               w_hit;

    assign w_tick = i_en && (r_presc == i_prescale);
    assign w_hit  = w_tick && (r_count == i_compare);

    // Prescaler runs 0..PRESCALE while enabled; any COUNT or PRESCALE write restarts it
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_presc <= '0;
        end else if (i_count_load || i_presc_clear) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else if (i_en) begin
            r_presc <= r_presc + PRESC_W'(1);
        end
    end

    // COUNT advances on each tick; a software load takes priority over the tick
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_count <= 32'd0;
        end else if (i_count_load) begin
            r_count <= i_count_wdata;
        end else if (w_tick) begin
            if (w_hit && i_auto_reload) begin
                r_count <= 32'd0;
            end else begin
                r_count <= r_count + 32'd1;
            end
        end
    end

    // MATCH is sticky; a hardware hit beats a simultaneous write-1-to-clear
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_match <= 1'b0;
        end else if (w_hit) begin
            r_match <= 1'b1;
        end else if (i_match_clear) begin
            r_match <= 1'b0;
        end
    end

    assign o_count = r_count;
    assign o_match = r_match;
    assign o_irq   = r_match & i_irq_en;

endmodule

// File: rtl/axil_timer.sv
// AXI4-Lite slave wrapper for the timer: independent write and read FSMs,
// register decode with byte strobes, and the timer core instance.
module axil_timer
    import timer_pkg::*;
#(
    parameter int          ADDR_W        = 5,
    parameter int          PRESC_W       = 16,
    parameter logic [31:0] RESET_COMPARE = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic [31:0] awaddr,
    input  logic [2:0]  awprot,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready,
    input  logic [31:0] araddr,
    input  logic [2:0]  arprot,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready,
    output logic        irq
);

    // Keep the decoded low bits, dropping the byte offset within a word
    localparam logic [31:0] ADDR_MASK = ((32'd1 << ADDR_W) - 32'd1) & ~32'd3;

    wr_state_t          r_wstate, w_wstate_next;
    rd_state_t          r_rstate, w_rstate_next;

    logic               r_aw_done, r_w_done;
    logic [31:0]        r_awaddr, r_wdata;
    logic [3:0]         r_wstrb;
    logic [1:0]         r_bresp;
    logic [31:0]        r_rdata;
    logic [1:0]         r_rresp;

    logic [CTRL_W-1:0]  r_ctrl;
    logic [PRESC_W-1:0] r_prescale;
    logic [31:0]        r_compare;

    logic               w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs, w_commit;
    logic [31:0]        w_waddr, w_wdata, w_woff, w_roff;
    logic [3:0]         w_wstrb;
    logic               w_sel_ctrl, w_sel_presc, w_sel_count, w_sel_compare, w_sel_status;
    logic               w_wmapped, w_rmapped;
    logic [31:0]        w_rval;
    logic [31:0]        w_presc_ext, w_count;
    logic [31:0]        w_ctrl_wval, w_presc_wval, w_compare_wval, w_count_wval;
    logic               w_match, w_irq;
    logic               w_unused;

    assign w_unused = ^{awprot, arprot};

    // Ready/valid are pure functions of the FSM state and done flags
    assign awready = (r_wstate == W_IDLE) && !r_aw_done;
    assign wready  = (r_wstate == W_IDLE) && !r_w_done;
    assign bvalid  = (r_wstate == W_RESP);
    assign bresp   = r_bresp;
    assign arready = (r_rstate == R_IDLE);
    assign rvalid  = (r_rstate == R_RESP);
    assign rdata   = r_rdata;
    assign rresp   = r_rresp;
    assign irq     = w_irq;

    assign w_aw_hs  = awvalid && awready;
    assign w_w_hs   = wvalid && wready;
    assign w_b_hs   = bvalid && bready;
    assign w_ar_hs  = arvalid && arready;
    assign w_r_hs   = rvalid && rready;
    assign w_commit = (r_wstate == W_IDLE) && (r_aw_done || w_aw_hs) && (r_w_done || w_w_hs);

    // The later of AW/W may be handshaking right now, so use the live bus value then
    assign w_waddr = w_aw_hs ? awaddr : r_awaddr;
    assign w_wdata = w_w_hs  ? wdata  : r_wdata;
    assign w_wstrb = w_w_hs  ? wstrb  : r_wstrb;
    assign w_woff  = w_waddr & ADDR_MASK;
    assign w_roff  = araddr & ADDR_MASK;

    assign w_presc_ext    = 32'(r_prescale);
    assign w_ctrl_wval    = apply_wstrb(32'(r_ctrl), w_wdata, w_wstrb);
    assign w_presc_wval   = apply_wstrb(w_presc_ext, w_wdata, w_wstrb);
    assign w_compare_wval = apply_wstrb(r_compare, w_wdata, w_wstrb);
    assign w_count_wval   = apply_wstrb(w_count, w_wdata, w_wstrb);

    // Write address decode; unmapped offsets are flagged for SLVERR
    always_comb begin
        w_sel_ctrl    = 1'b0;
        w_sel_presc   = 1'b0;
        w_sel_count   = 1'b0;
        w_sel_compare = 1'b0;
        w_sel_status  = 1'b0;
        w_wmapped     = 1'b1;
        case (w_woff)
            OFF_CTRL:     w_sel_ctrl    = 1'b1;
            OFF_PRESCALE: w_sel_presc   = 1'b1;
            OFF_COUNT:    w_sel_count   = 1'b1;
            OFF_COMPARE:  w_sel_compare = 1'b1;
            OFF_STATUS:   w_sel_status  = 1'b1;
            default:      w_wmapped     = 1'b0;
        endcase
    end

    // Read data mux over the current register values; unmapped reads return 0
    always_comb begin
        w_rval    = 32'd0;
        w_rmapped = 1'b1;
        case (w_roff)
            OFF_CTRL:     w_rval = 32'(r_ctrl);
            OFF_PRESCALE: w_rval = w_presc_ext;
            OFF_COUNT:    w_rval = w_count;
            OFF_COMPARE:  w_rval = r_compare;
            OFF_STATUS:   w_rval = {31'd0, w_match};
            default:      w_rmapped = 1'b0;
        endcase
    end

    // Write FSM state register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_wstate <= W_IDLE;
        end else begin
            r_wstate <= w_wstate_next;
        end
    end

    // Write FSM next state: commit moves to RESP, the B handshake returns to IDLE
    always_comb begin
        w_wstate_next = r_wstate;
        case (r_wstate)
            W_IDLE:  if (w_commit) w_wstate_next = W_RESP;
            W_RESP:  if (w_b_hs)   w_wstate_next = W_IDLE;
            default: w_wstate_next = W_IDLE;
        endcase
    end

    // Latch AW and W payloads independently; both flags clear once B is accepted
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_awaddr  <= 32'd0;
            r_wdata   <= 32'd0;
            r_wstrb   <= 4'd0;
        end else if (w_b_hs) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            if (w_aw_hs) begin
                r_aw_done <= 1'b1;
                r_awaddr  <= awaddr;
            end
            if (w_w_hs) begin
                r_w_done <= 1'b1;
                r_wdata  <= wdata;
                r_wstrb  <= wstrb;
            end
        end
    end

    // Register writes and the B response code are decided at the commit edge
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_ctrl     <= '0;
            r_prescale <= '0;
            r_compare  <= RESET_COMPARE;
            r_bresp    <= RESP_OKAY;
        end else if (w_commit) begin
            r_bresp <= w_wmapped ? RESP_OKAY : RESP_SLVERR;
            if (w_sel_ctrl)    r_ctrl     <= CTRL_W'(w_ctrl_wval);
            if (w_sel_presc)   r_prescale <= PRESC_W'(w_presc_wval);
            if (w_sel_compare) r_compare  <= w_compare_wval;
        end
    end

    // Read FSM state register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_rstate <= R_IDLE;
        end else begin
            r_rstate <= w_rstate_next;
        end
    end

    // Read FSM next state: AR handshake moves to RESP, R handshake returns to IDLE
    always_comb begin
        w_rstate_next = r_rstate;
        case (r_rstate)
            R_IDLE:  if (w_ar_hs) w_rstate_next = R_RESP;
            R_RESP:  if (w_r_hs)  w_rstate_next = R_IDLE;
            default: w_rstate_next = R_IDLE;
        endcase
    end

    // Capture read data and response on the AR handshake and hold them until accepted
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_rdata <= 32'd0;
            r_rresp <= RESP_OKAY;
        end else if (w_ar_hs) begin
            r_rdata <= w_rval;
            r_rresp <= w_rmapped ? RESP_OKAY : RESP_SLVERR;
        end
    end

    axil_timer_core #(
        .PRESC_W (PRESC_W)
    ) u_core (
        .clk           (clk),
        .nrst          (nrst),
        .i_en          (r_ctrl[CTRL_EN]),
        .i_irq_en      (r_ctrl[CTRL_IRQ_EN]),
        .i_auto_reload (r_ctrl[CTRL_AUTO_RELOAD]),
        .i_prescale    (r_prescale),
        .i_compare     (r_compare),
        .i_count_load  (w_commit && w_sel_count),
        .i_count_wdata (w_count_wval),
        .i_presc_clear (w_commit && w_sel_presc),
        .i_match_clear (w_commit && w_sel_status && w_wstrb[0] && w_wdata[0]),
        .o_count       (w_count),
        .o_match       (w_match),
        .o_irq         (w_irq)
    );

endmodule
